// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared pipeline slot type and forwarding-select
// encodings for the ID-stage forwarding/hazard control.
package rv_pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_IDEX  = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              cgra;
  } slot_t;

  // A slot forwards only if it really writes a non-x0 register.
  function automatic logic writes_reg(
    input slot_t             s,
    input logic [REG_AW-1:0] r
  );
    return s.valid & s.reg_write &
           (s.rd != '0) & (s.rd == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage operand info in, forwarding
// selects, stall and stall count out.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_reg_write_i;
  logic              id_mem_read_i;
  logic              id_cgra_i;
  logic              cgra_done_i;
  logic              flush_i;
  logic              mem_stall_i;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i,
    output id_use_rs1_i, id_use_rs2_i,
    output id_rd_i, id_reg_write_i,
    output id_mem_read_i, id_cgra_i,
    output cgra_done_i, flush_i, mem_stall_i,
    input  fwd_a_o, fwd_b_o, stall_o,
    input  stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i,
    input  id_use_rs1_i, id_use_rs2_i,
    input  id_rd_i, id_reg_write_i,
    input  id_mem_read_i, id_cgra_i,
    input  cgra_done_i, flush_i, mem_stall_i,
    output fwd_a_o, fwd_b_o, stall_o,
    output stall_cnt_o
  );

endinterface

// File: rtl/fwd_hazard_ctrl_sel.sv
// fwd_sel: one operand's forwarding select and load-use match
// against the EX/MEM/WB shadow slots.
module fwd_sel
  import rv_pipe_pkg::*;
(
  input  logic              use_i,
  input  logic [REG_AW-1:0] rs_i,
  input  slot_t             ex_i,
  input  slot_t             mem_i,
  input  slot_t             wb_i,
  output logic [1:0]        sel_o,
  output logic              load_hit_o
);

  logic rs_live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic unused_fields;

  assign unused_fields = ^{ex_i.cgra, mem_i.cgra,
                           wb_i.cgra, wb_i.mem_read};

  // Youngest matching writer wins; a load in EX or MEM blocks.
  always_comb begin
    rs_live = use_i & (rs_i != '0);
    ex_hit  = rs_live & writes_reg(ex_i, rs_i);
    mem_hit = rs_live & writes_reg(mem_i, rs_i);
    wb_hit  = rs_live & writes_reg(wb_i, rs_i);
    load_hit_o = (ex_hit & ex_i.mem_read) |
                 (mem_hit & mem_i.mem_read);
    sel_o = FWD_RF;
    priority case (1'b1)
      ex_hit:  sel_o = FWD_IDEX;
      mem_hit: sel_o = FWD_EXMEM;
      wb_hit:  sel_o = FWD_MEMWB;
      default: sel_o = FWD_RF;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding selects, load-use / CGRA-busy
// stall, bubble injection and saturating stall counter.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic              clk_i,
  input logic              rst_n_i,
  fwd_hazard_ctrl_if.slave bus
);
  import rv_pipe_pkg::slot_t;

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  slot_t            id_slot;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_AW-1:0] id_rd;
  logic [1:0]       sel_a, sel_b;
  logic             hit_a, hit_b;
  logic             cgra_busy;
  logic             hazard;
  logic             stall;

  assign id_rd = bus.id_rd_i;

  fwd_sel u_sel_a (
    .use_i      (bus.id_use_rs1_i),
    .rs_i       (bus.id_rs1_i),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (sel_a),
    .load_hit_o (hit_a)
  );

  fwd_sel u_sel_b (
    .use_i      (bus.id_use_rs2_i),
    .rs_i       (bus.id_rs2_i),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (sel_b),
    .load_hit_o (hit_b)
  );

  // Hazard detection and output drive, same cycle as ID.
  always_comb begin
    cgra_busy = ex_q.valid & ex_q.cgra &
                ~bus.cgra_done_i;
    hazard = bus.id_valid_i &
             (hit_a | hit_b | cgra_busy);
    stall  = hazard | bus.mem_stall_i;
    bus.fwd_a_o     = sel_a;
    bus.fwd_b_o     = sel_b;
    bus.stall_o     = stall;
    bus.stall_cnt_o = cnt_q;
  end

  // Slot advance. A busy CGRA op holds EX even with no
  // valid ID instruction, so it never leaves EX undone.
  always_comb begin
    id_slot.valid     = bus.id_valid_i & ~bus.flush_i;
    id_slot.rd        = id_rd;
    id_slot.reg_write = bus.id_reg_write_i;
    id_slot.mem_read  = bus.id_mem_read_i;
    id_slot.cgra      = bus.id_cgra_i;
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    priority case (1'b1)
      bus.mem_stall_i: ;
      cgra_busy: begin
        mem_d = '0;
        wb_d  = mem_q;
      end
      hazard: begin
        ex_d  = '0;
        mem_d = ex_q;
        wb_d  = mem_q;
      end
      default: begin
        ex_d  = id_slot;
        mem_d = ex_q;
        wb_d  = mem_q;
      end
    endcase
  end

  // Stall counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Slot and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Generates the 2-bit operand-source selects consumed by the two operand forwarding multiplexers in the ID stage.
  - 00 = register file
  - 01 = ID/EX result
  - 10 = EX/MEM result
  - 11 = MEM/WB result
- Keeps its own shadow pipeline of destination-register metadata for the EX, MEM and WB slots.
- Detects load-use and CGRA-busy hazards, stalls the front end, and injects bubbles.
- Counts stall cycles for performance debug.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, stall-counter width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i  in  REG_AW  ID source register 1
- id_rs2_i  in  REG_AW  ID source register 2
- id_use_rs1_i  in  1  instruction reads rs1
- id_use_rs2_i  in  1  instruction reads rs2
- id_rd_i  in  REG_AW  ID destination register
- id_reg_write_i  in  1  ID writes rd
- id_mem_read_i  in  1  ID is a load
- id_cgra_i  in  1  ID is a CGRA custom op
- cgra_done_i  in  1  CGRA result valid this cycle
- flush_i  in  1  kill the ID instruction (taken branch)
- mem_stall_i  in  1  global freeze from the memory system
- fwd_a_o  out  2  select for operand A
- fwd_b_o  out  2  select for operand B
- stall_o  out  1  hold PC and IF/ID
- stall_cnt_o  out  CNT_W  saturating stall-cycle count

Behaviour:
- Slots: EX, MEM and WB each hold {valid, rd, reg_write, mem_read, cgra}.
  - All are registers, cleared to 0 asynchronously when rst_n_i = 0.
  - Reset values: fwd_*_o = 00, stall_o = 0, stall_cnt_o = 0.
- Writer qualifier: a slot is a writer iff valid & reg_write & rd != 0. x0 is never forwarded.
- Select for each operand (combinational from the slots and ID inputs), highest priority first:
  - If use_rsX = 0 or rsX = 0 → 00.
  - EX writer match → 01.
  - MEM writer match → 10.
  - WB writer match → 11.
  - Otherwise → 00.
- Hazard (combinational), asserted iff id_valid_i and any of:
  - (a) EX is a writer with mem_read = 1 matching a used rs (load-use; 1 bubble).
  - (b) MEM is a writer with mem_read = 1 matching a used rs (load data not ready until WB; 1 more bubble).
  - (c) EX holds a cgra op and cgra_done_i = 0. This is independent of dependency, because the CGRA op occupies EX.
- stall_o = hazard | mem_stall_i.
- Clock update, in order of precedence:
  1. mem_stall_i = 1: all slots hold. Has priority over flush_i and hazards.
  2. cgra_busy (case (c)): EX holds; MEM ← bubble; WB ← MEM.
  3. Hazard (a)/(b): EX ← bubble; MEM ← EX; WB ← MEM.
  4. Otherwise: EX ← ID fields, valid = id_valid_i & ~flush_i; MEM ← EX; WB ← MEM.
- flush_i during a hazard: the ID instruction is still blocked; the EX bubble is inserted as normal.
- After a stall ends, selects re-evaluate against the advanced slots. For a load-use, the dependent instruction sees 11 two cycles after the load left ID.
- cgra_done_i while EX holds no cgra op: ignored.
- stall_cnt_o increments on every cycle with stall_o = 1 and saturates at all-ones; no wrap.
- Latency: selects and stall_o are valid in the same cycle as the ID inputs (0-cycle). Slot state is 1-cycle.

Decomposition:
- Shared package, rv_pipe_pkg, contains:
  - fwd-select constants FWD_RF = 00, FWD_IDEX = 01, FWD_EXMEM = 10, FWD_MEMWB = 11
  - REG_AW
  - the packed slot struct {valid, rd, reg_write, mem_read, cgra}
- Sub-module fwd_sel: purely combinational single-operand select and hazard match, instantiated twice (operand A and operand B).

Test Plan:
- add x5 then add x6,x5,x5 back-to-back → fwd_a_o = fwd_b_o = 01, stall_o = 0; the next cycle with independent ID → 00.
- lw x7 then add x8,x7,x0 → stall_o = 1 for 2 cycles, stall_cnt_o = 2; then fwd_a_o = 11, fwd_b_o = 00.
- Writes to x0 in EX/MEM/WB with ID reading x0 → selects 00 throughout. Same rd in EX and WB → 01 wins.
- CGRA op in EX, cgra_done_i low 4 cycles then high → stall_o high exactly 4 cycles; MEM gets 4 bubbles; the op moves to MEM on the done cycle.
- mem_stall_i high 3 cycles mid load-use → slots frozen, stall_o high; stall_cnt_o counts all 3 plus the hazard cycles; flush_i during the freeze has no effect.
- rst_n_i asserted mid-CGRA stall (asynchronous, off-edge) → all outputs 0 immediately. Preload stall_cnt_o near max → it saturates at all-ones.
